// File: rtl/oled_level_meter.sv
// oled_level_meter: windowed mic peak -> bar level -> RGB565 bar graph for the 96x64 PmodOLED.
// Optional peak-hold marker enabled by defining OLED_METER_PEAK_HOLD_EN.
module oled_level_meter #(
  parameter int MIC_W       = 12,
  parameter int SCREEN_W    = 96,
  parameter int SCREEN_H    = 64,
  parameter int LEVELS      = 16,
  parameter int WINDOW      = 4000,
  parameter int BAR_X0      = 40,
  parameter int BAR_X1      = 56,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_en,
  input  logic [MIC_W-1:0]              mic_in,
  input  logic                          frame_begin,
  input  logic [12:0]                   pixel_index,
  output logic [15:0]                   pixel_data,
  output logic [$clog2(LEVELS+1)-1:0]   level,
  output logic                          level_valid
);
  localparam int LW    = $clog2(LEVELS+1);
  localparam int QW    = MIC_W + $clog2(LEVELS) + 1;
  localparam int CW    = $clog2(WINDOW);
  localparam int ROW_H = SCREEN_H / LEVELS;
  localparam int NPIX  = SCREEN_W * SCREEN_H;
  logic [MIC_W-1:0] win_max, peak;
  logic [CW-1:0]    win_cnt;
  logic [LW-1:0]    new_level, disp_level, k;
  logic [12:0]      x, y, r;
  logic             win_end, lit, marker;
  logic [15:0]      colour;
  assign peak      = mic_in > win_max ? mic_in : win_max;
  assign win_end   = sample_en && win_cnt == CW'(WINDOW-1);
  assign new_level = LW'(((QW'(peak) + QW'(1)) * QW'(LEVELS)) >> MIC_W);
  assign x   = pixel_index % 13'(SCREEN_W);
  assign y   = pixel_index / 13'(SCREEN_W);
  // r counts rows up from the bottom edge; only meaningful for in-range indices
  assign r   = 13'(SCREEN_H-1) - y;
  assign k   = LW'(r / 13'(ROW_H) + 13'd1);
  assign lit = pixel_index < 13'(NPIX) && x >= 13'(BAR_X0) && x < 13'(BAR_X1)
               && r % 13'(ROW_H) != 13'(ROW_H-1);
`ifdef OLED_METER_PEAK_HOLD_EN
  localparam int FW = $clog2(HOLD_FRAMES+1);
  logic [LW-1:0] hold, disp_hold, hold_dec, hold_nxt;
  logic [FW-1:0] frame_cnt;
  logic          wrap;
  assign wrap     = frame_begin && frame_cnt == FW'(HOLD_FRAMES-1);
  assign hold_dec = hold == '0 ? '0 : hold - LW'(1);
  assign marker   = disp_hold != '0 && k == disp_hold;
  always_comb begin
    hold_nxt = wrap ? (hold_dec > level ? hold_dec : level) : hold;
    hold_nxt = win_end && new_level > hold_nxt ? new_level : hold_nxt;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hold      <= '0;
      disp_hold <= '0;
      frame_cnt <= '0;
    end else begin
      hold <= hold_nxt;
      if (frame_begin) begin
        disp_hold <= hold;
        frame_cnt <= wrap ? '0 : frame_cnt + FW'(1);
      end
    end
`else
  assign marker = 1'b0;
`endif
  assign colour = !lit ? 16'h0000 :
                  marker ? 16'hFFFF :
                  k > disp_level ? 16'h0000 :
                  k <= LW'(LEVELS/2) ? 16'h07E0 :
                  k <= LW'(3*LEVELS/4) ? 16'hFFE0 : 16'hF800;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      win_max     <= '0;
      win_cnt     <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      disp_level  <= '0;
      pixel_data  <= 16'h0000;
    end else begin
      level_valid <= win_end;
      if (sample_en) begin
        win_max <= win_end ? '0 : peak;
        win_cnt <= win_end ? '0 : win_cnt + CW'(1);
      end
      if (win_end) level <= new_level;
      // takes the pre-update level when a window ends on the same edge
      if (frame_begin) disp_level <= level;
      pixel_data <= colour;
    end
endmodule
